// File: rtl/gate_id_pkg.sv
// gate_id_pkg: gate codes, reference truth tables, FSM states and the table decoder.
package gate_id_pkg;
    typedef enum logic [3:0] {
        G_NONE    = 4'd0,
        G_AND     = 4'd1,
        G_OR      = 4'd2,
        G_NOT_A   = 4'd3,
        G_NAND    = 4'd4,
        G_NOR     = 4'd5,
        G_XOR     = 4'd6,
        G_XNOR    = 4'd7,
        G_CONST0  = 4'd8,
        G_CONST1  = 4'd9,
        G_BUF_A   = 4'd10,
        G_BUF_B   = 4'd11,
        G_NOT_B   = 4'd12,
        G_UNKNOWN = 4'd15
    } gate_id_t;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    localparam logic [3:0] TT_AND    = 4'b1000;
    localparam logic [3:0] TT_OR     = 4'b1110;
    localparam logic [3:0] TT_NOT_A  = 4'b0011;
    localparam logic [3:0] TT_NAND   = 4'b0111;
    localparam logic [3:0] TT_NOR    = 4'b0001;
    localparam logic [3:0] TT_XOR    = 4'b0110;
    localparam logic [3:0] TT_XNOR   = 4'b1001;
    localparam logic [3:0] TT_CONST0 = 4'b0000;
    localparam logic [3:0] TT_CONST1 = 4'b1111;
    localparam logic [3:0] TT_BUF_A  = 4'b1100;
    localparam logic [3:0] TT_BUF_B  = 4'b1010;
    localparam logic [3:0] TT_NOT_B  = 4'b0101;
    function automatic gate_id_t classify(input logic [3:0] tt);
        case (tt)
            TT_AND:    return G_AND;
            TT_OR:     return G_OR;
            TT_NOT_A:  return G_NOT_A;
            TT_NAND:   return G_NAND;
            TT_NOR:    return G_NOR;
            TT_XOR:    return G_XOR;
            TT_XNOR:   return G_XNOR;
            TT_CONST0: return G_CONST0;
            TT_CONST1: return G_CONST1;
            TT_BUF_A:  return G_BUF_A;
            TT_BUF_B:  return G_BUF_B;
            TT_NOT_B:  return G_NOT_B;
            default:   return G_UNKNOWN;
        endcase
    endfunction
endpackage

// File: rtl/gate_identifier.sv
// gate_identifier: sweeps a two-input DUP through 00..11, captures its output
// into a truth table and decodes the gate identity.
module gate_identifier
    import gate_id_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       probe_a,
    output logic       probe_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [3:0] gate_id
);
    localparam logic [3:0] S = 4'(SETTLE_CYCLES);
    state_t     state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic [3:0] tt_next;
    // table including the bit captured on this sample edge, so the decode sees all four
    always_comb begin
        tt_next = truth_table;
        tt_next[idx] = dut_y;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= 2'd0;
            cnt <= 4'd0;
            probe_a <= 1'b0;
            probe_b <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            truth_table <= 4'd0;
            gate_id <= G_NONE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= DRIVE;
                    idx <= 2'd0;
                    cnt <= S;
                    truth_table <= 4'd0;
                    busy <= 1'b1;
                    {probe_a, probe_b} <= 2'b00;
                end
                DRIVE: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    truth_table <= tt_next;
                    if (idx == 2'd3) begin
                        state <= DONE;
                        done <= 1'b1;
                        {probe_a, probe_b} <= 2'b00;
                        gate_id <= classify(tt_next);
                    end else begin
                        idx <= idx + 2'd1;
                        cnt <= S;
                        {probe_a, probe_b} <= idx + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gate_identifier.md
# gate_identifier

- Probing initiator that drives a two-input combinational device-under-probe (DUP) through all four input vectors, captures its single output, and reports the recovered truth table plus a decoded gate identity.
- It is the driving/observing end of the two-input gate interface: the gate library computes outputs from inputs; this block recovers the function from outputs.
- Sits in the lab self-check harness, between a start strobe from the bench controller and any gate instance wired to its probe ports.

## Interface
Parameters:
- SETTLE_CYCLES, 1, extra cycles each probe vector is held before sampling; legal 0..15.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only when busy=0.
- probe_a  output  1  drives DUP input A.
- probe_b  output  1  drives DUP input B.
- dut_y  input  1  DUP output; must be stable before the sample edge.
- busy  output  1  high from the first probe cycle through the done cycle inclusive.
- done  output  1  one-cycle pulse; truth_table and gate_id are valid from this cycle.
- truth_table  output  4  bit index {a,b} = DUP output for that vector.
- gate_id  output  4  decoded gate_id_t code.

## Operation
States:
- IDLE: probes=00, busy=0.
  - start=1 → DRIVE with idx=0 and settle counter=SETTLE_CYCLES.
  - truth_table is cleared to 0 on entry to DRIVE.
- DRIVE: {probe_a,probe_b}=idx.
  - Counter>0 → decrement.
  - Counter=0 → truth_table[idx] <= dut_y on that edge.
    - idx=3 → DONE.
    - Otherwise → idx+1, counter reloads SETTLE_CYCLES.
- DONE: one cycle, done=1, busy=1, probes=00 → IDLE.
  - gate_id is registered from truth_table on entry to DONE, i.e. decoded from the full 4-bit table.

Decode, with bits [3:0] = vectors 11,10,01,00:
- Gate codes: AND 1000→1, OR 1110→2, NOT_A 0011→3, NAND 0111→4, NOR 0001→5, XOR 0110→6, XNOR 1001→7.
- Constant and pass-through codes: CONST0 0000→8, CONST1 1111→9, BUF_A 1100→10, BUF_B 1010→11, NOT_B 0101→12.
- All other tables → UNKNOWN=15. Code 0 = NONE (no sweep completed).

Output holding:
- truth_table holds after done until the next accepted start clears it.
- gate_id holds until it is overwritten at the next DONE.

Boundary conditions:
- start while busy=1, including the DONE cycle: ignored, no queuing.
- start asserted continuously from IDLE: a new sweep begins the cycle after DONE returns to IDLE.
- rst at any state: next cycle IDLE with all outputs at reset values; a partial sweep is discarded.
- rst and start in the same cycle: rst wins.
- dut_y is sampled only on DRIVE sample edges; it is ignored otherwise.

## Timing
- Reset values: probe_a=0, probe_b=0, busy=0, done=0, truth_table=0000, gate_id=0 (NONE).
- start sampled high at edge E0; cycle n is the cycle following edge E(n-1).
- Vector i is driven in cycles i·(S+1)+1 .. (i+1)·(S+1), where S=SETTLE_CYCLES.
- dut_y is sampled on the edge ending the last of those cycles.
- done is high in cycle 4·(S+1)+1.
  - S=1 → cycle 9.
  - S=0 → cycle 5.
- busy is high in cycles 1 .. 4·(S+1)+1.
- Earliest next accepted start: edge at the end of the first IDLE cycle after done.
- SETTLE_CYCLES=0 requires a purely combinational DUP path within one cycle.

## Structure
- Package gate_id_pkg holds:
  - gate_id_t enum (4-bit, codes above);
  - the 4-bit truth-table localparams (TT_AND … TT_CONST1);
  - state_t enum {IDLE, DRIVE, DONE};
  - a function classify(logic [3:0] tt) returning gate_id_t.
- Counter width is $clog2(16)=4 bits, fixed by the SETTLE_CYCLES range; the index is 2 bits.
- No sub-module: FSM, index, settle counter and capture register stay in one module; decode stays in the package function.
- The bench instantiates basic_gates as the DUP, muxing one output to dut_y.

## Test plan
- Reset, then idle 5 cycles → all outputs at reset values, busy=0, gate_id=0.
- S=1, DUP=AND → probes 00,01,10,11 each held 2 cycles; done in cycle 9; truth_table=1000; gate_id=1.
- Sweep each basic_gates output in turn (OR, NOT_A, NAND, NOR, XOR, XNOR) → gate_id 2,3,4,5,6,7 respectively.
- DUP tied to 0, then 1, then to B → gate_id 8, 9, 11.
- S=0, DUP=XOR → done in cycle 5, truth_table=0110.
- Forced table 0010 → gate_id=15.
- Mid-sweep behaviour:
  - start re-pulsed in cycles 3 and 9 of a sweep → ignored, single done.
  - rst asserted in cycle 4 → next cycle IDLE with reset values and no done.
  - A fresh start then completes normally.
